lpa_tile_accumulator: RTL and testbench

Accumulates the partial-sum output streams of the parallelized linear processing array across multiple tile passes, so one array can compute a matrix product whose reduction dimension exceeds PE_NUMBER_J. It sits directly after the array's down (D) output. It holds one running sum per lane per beat position, and emits the finished signed fixed-point results only on the final tile. It also flags lane misalignment and tile-length mismatch.

---
 rtl/lpa_tile_accumulator.sv | 254 +++++++++++++++++++++++++
 tb/tb_lpa_tile_accumulator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lpa_tile_accumulator.sv
// Accumulates LPA partial-sum tiles per lane/beat and emits the final-tile sums.
// Define LPA_ACC_SATURATE_EN to clamp results on output; default build wraps.

module lpa_tile_accumulator_lane #(
   parameter int DIN    = 16,
   parameter int ACC    = 24,
   parameter int DOUT   = 16,
   parameter int DEPTH  = 16,
   parameter int AW     = 4,
   parameter int IDW    = 1,
   parameter int DESTW  = 1,
   parameter int USERW  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic             use_acc,
   input  logic             ld_out,
   input  logic [AW-1:0]    addr,
   input  logic [DIN-1:0]   din,
   input  logic             tlast_in,
   input  logic [IDW-1:0]   tid_in,
   input  logic [DESTW-1:0] tdest_in,
   input  logic [USERW-1:0] tuser_in,
   output logic [DOUT-1:0]  dout,
   output logic             tlast_out,
   output logic [IDW-1:0]   tid_out,
   output logic [DESTW-1:0] tdest_out,
   output logic [USERW-1:0] tuser_out
);
   logic [ACC-1:0]   mem [DEPTH];
   logic [ACC-1:0]   sum;
   logic [DOUT-1:0]  res;
   logic [DOUT-1:0]  dout_q, dout_d;
   logic             tlast_q, tlast_d;
   logic [IDW-1:0]   tid_q, tid_d;
   logic [DESTW-1:0] tdest_q, tdest_d;
   logic [USERW-1:0] tuser_q, tuser_d;

   // Combinational read: a write on one edge is already visible to the next
   // beat at the same address, so back-to-back L=1 tiles need no forwarding.
   always_comb sum = (use_acc ? mem[addr] : '0) + ACC'($signed(din));

   always_ff @(posedge clk) begin
      if (wr_en) mem[addr] <= sum;
   end

`ifdef LPA_ACC_SATURATE_EN
   logic [ACC-DOUT:0] hi;
   always_comb begin
      hi = sum[ACC-1:DOUT-1];
      if ((&hi) || !(|hi)) res = sum[DOUT-1:0];
      else if (sum[ACC-1]) res = {1'b1, {(DOUT-1){1'b0}}};
      else                 res = {1'b0, {(DOUT-1){1'b1}}};
   end
`else
   always_comb res = sum[DOUT-1:0];
`endif

   always_comb begin
      dout_d  = dout_q;
      tlast_d = tlast_q;
      tid_d   = tid_q;
      tdest_d = tdest_q;
      tuser_d = tuser_q;
      if (ld_out) begin
         dout_d  = res;
         tlast_d = tlast_in;
         tid_d   = tid_in;
         tdest_d = tdest_in;
         tuser_d = tuser_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q  <= '0;
         tlast_q <= 1'b0;
         tid_q   <= '0;
         tdest_q <= '0;
         tuser_q <= '0;
      end else begin
         dout_q  <= dout_d;
         tlast_q <= tlast_d;
         tid_q   <= tid_d;
         tdest_q <= tdest_d;
         tuser_q <= tuser_d;
      end
   end

   assign dout      = dout_q;
   assign tlast_out = tlast_q;
   assign tid_out   = tid_q;
   assign tdest_out = tdest_q;
   assign tuser_out = tuser_q;
endmodule

module lpa_tile_accumulator #(
   parameter int LANES          = 1,
   parameter int DATA_WIDTH_IN  = 16,
   parameter int ACC_WIDTH      = 24,
   parameter int DATA_WIDTH_OUT = 16,
   parameter int DEPTH          = 16,
   parameter int TILE_WIDTH     = 8,
   parameter int ID_WIDTH       = 1,
   parameter int DEST_WIDTH     = 1,
   parameter int USER_WIDTH     = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [TILE_WIDTH-1:0]             cfg_tiles,
   input  logic [LANES*DATA_WIDTH_IN-1:0]    s_axis_p_tdata,
   input  logic [LANES-1:0]                  s_axis_p_tvalid,
   output logic [LANES-1:0]                  s_axis_p_tready,
   input  logic [LANES-1:0]                  s_axis_p_tlast,
   input  logic [LANES*ID_WIDTH-1:0]         s_axis_p_tid,
   input  logic [LANES*DEST_WIDTH-1:0]       s_axis_p_tdest,
   input  logic [LANES*USER_WIDTH-1:0]       s_axis_p_tuser,
   output logic [LANES*DATA_WIDTH_OUT-1:0]   m_axis_r_tdata,
   output logic [LANES-1:0]                  m_axis_r_tvalid,
   input  logic [LANES-1:0]                  m_axis_r_tready,
   output logic [LANES-1:0]                  m_axis_r_tlast,
   output logic [LANES*ID_WIDTH-1:0]         m_axis_r_tid,
   output logic [LANES*DEST_WIDTH-1:0]       m_axis_r_tdest,
   output logic [LANES*USER_WIDTH-1:0]       m_axis_r_tuser,
   output logic                              busy,
   output logic                              err_unaligned_data
);
   localparam int BC_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [BC_W-1:0] BC_MAX = BC_W'(DEPTH - 1);

   typedef enum logic [1:0] {ST_FIRST, ST_MID, ST_LAST} state_t;

   state_t                state_q, state_d;
   logic [BC_W-1:0]       bc_q, bc_d;
   logic [BC_W-1:0]       len_q, len_d;
   logic [TILE_WIDTH-1:0] tc_q, tc_d;
   logic [TILE_WIDTH-1:0] tiles_q, tiles_d;
   logic                  out_vld_q, out_vld_d;
   logic                  err_q, err_d;

   logic [TILE_WIDTH-1:0] cfg_norm, eff_tiles;
   logic group_start, final_tile, out_free, in_ready, in_acc, out_acc, tlast0;

   always_comb begin
      cfg_norm    = (cfg_tiles == '0) ? TILE_WIDTH'(1) : cfg_tiles;
      group_start = (state_q == ST_FIRST) && (bc_q == '0);
      eff_tiles   = group_start ? cfg_norm : tiles_q;
      // A one-tile group is its own final tile, so FIRST then acts like LAST.
      final_tile  = (state_q == ST_LAST) ||
                    ((state_q == ST_FIRST) && (eff_tiles == TILE_WIDTH'(1)));
      out_free    = !out_vld_q || (&m_axis_r_tready);
      in_ready    = !rst && (!final_tile || out_free);
      in_acc      = (&s_axis_p_tvalid) && in_ready;
      out_acc     = out_vld_q && (&m_axis_r_tready);
      tlast0      = s_axis_p_tlast[0];
   end

   always_comb begin
      state_d   = state_q;
      bc_d      = bc_q;
      len_d     = len_q;
      tc_d      = tc_q;
      tiles_d   = tiles_q;
      err_d     = err_q;
      out_vld_d = out_vld_q;
      if (out_acc) out_vld_d = 1'b0;
      if (in_acc) begin
         if (final_tile) out_vld_d = 1'b1;
         if (group_start) tiles_d = cfg_norm;
         if (s_axis_p_tlast != {LANES{tlast0}}) err_d = 1'b1;
         if (tlast0) begin
            bc_d = '0;
            if (tc_q == '0) len_d = bc_q;
            else if (bc_q != len_q) err_d = 1'b1;
            case (state_q)
               ST_FIRST: begin
                  if (eff_tiles == TILE_WIDTH'(1)) begin
                     tc_d = '0;
                  end else begin
                     tc_d    = TILE_WIDTH'(1);
                     state_d = (eff_tiles == TILE_WIDTH'(2)) ? ST_LAST : ST_MID;
                  end
               end
               ST_MID: begin
                  tc_d = tc_q + TILE_WIDTH'(1);
                  if (tc_q == tiles_q - TILE_WIDTH'(2)) state_d = ST_LAST;
               end
               default: begin
                  tc_d    = '0;
                  state_d = ST_FIRST;
               end
            endcase
         end else if (bc_q == BC_MAX) begin
            err_d = 1'b1;
         end else begin
            bc_d = bc_q + BC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_FIRST;
         bc_q      <= '0;
         len_q     <= '0;
         tc_q      <= '0;
         tiles_q   <= TILE_WIDTH'(1);
         out_vld_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bc_q      <= bc_d;
         len_q     <= len_d;
         tc_q      <= tc_d;
         tiles_q   <= tiles_d;
         out_vld_q <= out_vld_d;
         err_q     <= err_d;
      end
   end

   genvar l;
   generate
      for (l = 0; l < LANES; l++) begin : g_lane
         lpa_tile_accumulator_lane #(
            .DIN(DATA_WIDTH_IN), .ACC(ACC_WIDTH), .DOUT(DATA_WIDTH_OUT),
            .DEPTH(DEPTH), .AW(BC_W), .IDW(ID_WIDTH), .DESTW(DEST_WIDTH),
            .USERW(USER_WIDTH)
         ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (in_acc && !final_tile),
            .use_acc   (state_q != ST_FIRST),
            .ld_out    (in_acc && final_tile),
            .addr      (bc_q),
            .din       (s_axis_p_tdata[l*DATA_WIDTH_IN +: DATA_WIDTH_IN]),
            .tlast_in  (s_axis_p_tlast[l]),
            .tid_in    (s_axis_p_tid[l*ID_WIDTH +: ID_WIDTH]),
            .tdest_in  (s_axis_p_tdest[l*DEST_WIDTH +: DEST_WIDTH]),
            .tuser_in  (s_axis_p_tuser[l*USER_WIDTH +: USER_WIDTH]),
            .dout      (m_axis_r_tdata[l*DATA_WIDTH_OUT +: DATA_WIDTH_OUT]),
            .tlast_out (m_axis_r_tlast[l]),
            .tid_out   (m_axis_r_tid[l*ID_WIDTH +: ID_WIDTH]),
            .tdest_out (m_axis_r_tdest[l*DEST_WIDTH +: DEST_WIDTH]),
            .tuser_out (m_axis_r_tuser[l*USER_WIDTH +: USER_WIDTH])
         );
      end
   endgenerate

   assign s_axis_p_tready    = {LANES{in_ready}};
   assign m_axis_r_tvalid    = {LANES{out_vld_q}};
   assign busy               = (state_q != ST_FIRST) || (bc_q != '0);
   assign err_unaligned_data = err_q;
endmodule

// File: tb/tb_lpa_tile_accumulator.sv
// Directed bench for lpa_tile_accumulator (2 lanes, 8-bit results) with a
// scoreboard queue filled by the stimulus and drained by an output monitor.

module tb_lpa_tile_accumulator;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  cfg_tiles = 8'd1;
   logic [31:0] s_tdata = '0;
   logic [1:0]  s_tvalid = '0, s_tready, s_tlast = '0;
   logic [1:0]  s_tid = '0, s_tdest = '0, s_tuser = '0;
   logic [15:0] m_tdata;
   logic [1:0]  m_tvalid, m_tready = '0, m_tlast, m_tid, m_tdest, m_tuser;
   logic        busy, err;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   logic ignore_out = 1'b0;

   typedef struct packed {
      logic [15:0] d;
      logic [1:0]  last;
      logic        id;
   } exp_t;
   exp_t exp_q[$];

`ifdef LPA_ACC_SATURATE_EN
   localparam logic [15:0] EXP_T3 = 16'h807F;
`else
   localparam logic [15:0] EXP_T3 = 16'h38C8;
`endif

   lpa_tile_accumulator #(
      .LANES(2), .DATA_WIDTH_IN(16), .ACC_WIDTH(24), .DATA_WIDTH_OUT(8),
      .DEPTH(16), .TILE_WIDTH(8), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)
   ) u_dut (
      .clk(clk), .rst(rst), .cfg_tiles(cfg_tiles),
      .s_axis_p_tdata(s_tdata), .s_axis_p_tvalid(s_tvalid),
      .s_axis_p_tready(s_tready), .s_axis_p_tlast(s_tlast),
      .s_axis_p_tid(s_tid), .s_axis_p_tdest(s_tdest), .s_axis_p_tuser(s_tuser),
      .m_axis_r_tdata(m_tdata), .m_axis_r_tvalid(m_tvalid),
      .m_axis_r_tready(m_tready), .m_axis_r_tlast(m_tlast),
      .m_axis_r_tid(m_tid), .m_axis_r_tdest(m_tdest), .m_axis_r_tuser(m_tuser),
      .busy(busy), .err_unaligned_data(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
      end
   endtask

   task automatic push(input logic [15:0] d, input logic [1:0] last, input logic id);
      exp_t e;
      e.d = d;
      e.last = last;
      e.id = id;
      exp_q.push_back(e);
   endtask

   // Output monitor: a handshake happens on the edge after this sample.
   always @(negedge clk) begin
      if (!rst && m_tvalid[0] && (&m_tready) && !ignore_out) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got %0h, expected none", m_tdata);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_data", 32'(m_tdata), 32'(e.d));
            chk("out_side", 32'({m_tlast, m_tid, m_tdest, m_tuser}),
                32'({e.last, {2{e.id}}, {2{~e.id}}, {2{e.id}}}));
         end
      end
   end

   task automatic drive(input int a, input int b, input logic [1:0] last, input logic id);
      s_tdata  = {16'(b), 16'(a)};
      s_tvalid = 2'b11;
      s_tlast  = last;
      s_tid    = {id, id};
      s_tdest  = {~id, ~id};
      s_tuser  = {id, id};
   endtask

   task automatic beat(input int a, input int b, input logic [1:0] last, input logic id);
      int n;
      drive(a, b, last, id);
      n = 0;
      forever begin
         @(negedge clk);
         if (s_tready == 2'b11) break;
         n++;
         if (n > 100) begin
            tests++;
            fails++;
            $display("FAIL beat_timeout: tready %b, expected 11", s_tready);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      s_tvalid = 2'b00;
      s_tlast  = 2'b00;
   endtask

   task automatic gap(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int c0, c1;
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_tready", 32'(s_tready), 32'h0);
      chk("rst_tvalid", 32'(m_tvalid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_data", 32'(m_tdata), 32'h0);
      rst = 1'b0;
      gap(2);

      // three tiles of four beats, ready sink
      cfg_tiles = 8'd3;
      m_tready  = 2'b11;
      c0 = 0;
      for (int t = 0; t < 3; t++) begin
         for (int k = 0; k < 4; k++) begin
            int v;
            logic [1:0] lst;
            v = k + 1;
            lst = (k == 3) ? 2'b11 : 2'b00;
            if (t == 2) push({8'(-3 * v), 8'(3 * v)}, lst, k[0]);
            beat(v, -v, lst, k[0]);
            if (t == 0 && k == 0) begin
               c0 = cyc;
               chk("t1_busy_mid", 32'(busy), 32'h1);
            end
         end
      end
      c1 = cyc;
      idle();
      chk("t1_beat_cycles", 32'(c1 - c0), 32'd11);
      chk("t1_out_latency", 32'({m_tvalid, m_tlast}), 32'hF);
      chk("t1_busy_done", 32'(busy), 32'h0);
      gap(2);

      // single-tile pass-through, sink stalls for five cycles
      cfg_tiles = 8'd1;
      m_tready  = 2'b00;
      push(16'hF907, 2'b11, 1'b1);
      beat(7, -7, 2'b11, 1'b1);
      chk("t2_latency", 32'(m_tvalid), 32'h3);
      push(16'hF808, 2'b11, 1'b0);
      drive(8, -8, 2'b11, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t2_stall_tready", 32'(s_tready), 32'h0);
         chk("t2_stall_hold", 32'({m_tvalid, m_tdata}), 32'h3F907);
      end
      @(posedge clk);
      #1;
      m_tready = 2'b11;
      beat(8, -8, 2'b11, 1'b0);
      cfg_tiles = 8'd0;
      push(16'hF60A, 2'b11, 1'b1);
      beat(10, -10, 2'b11, 1'b1);
      idle();
      gap(3);

      // two tiles of 100 / -100 with an 8-bit result
      cfg_tiles = 8'd2;
      beat(100, -100, 2'b11, 1'b0);
      push(EXP_T3, 2'b11, 1'b1);
      beat(100, -100, 2'b11, 1'b1);
      idle();
      gap(3);

      // L=1, four tiles back to back
      cfg_tiles = 8'd4;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) push(16'hEC14, 2'b11, 1'b1);
         beat(5, -5, 2'b11, i[0]);
      end
      idle();
      gap(3);

      // reset in the middle of tile 1, then a fresh two-tile group
      cfg_tiles = 8'd3;
      for (int k = 0; k < 4; k++) beat(k + 1, k + 1, (k == 3) ? 2'b11 : 2'b00, 1'b0);
      beat(50, 50, 2'b00, 1'b0);
      beat(50, 50, 2'b00, 1'b1);
      chk("t5_busy_mid", 32'(busy), 32'h1);
      drive(50, 50, 2'b00, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t5_rst_tready", 32'(s_tready), 32'h0);
      chk("t5_rst_busy", 32'(busy), 32'h0);
      chk("t5_rst_out", 32'({m_tvalid, m_tdata}), 32'h0);
      @(posedge clk);
      idle();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      gap(1);
      cfg_tiles = 8'd2;
      beat(10, -10, 2'b00, 1'b0);
      beat(20, -20, 2'b11, 1'b1);
      push(16'hF50B, 2'b00, 1'b0);
      beat(1, -1, 2'b00, 1'b0);
      push(16'hEA16, 2'b11, 1'b1);
      beat(2, -2, 2'b11, 1'b1);
      idle();
      gap(3);

      // misaligned lane tlast, then short second tile
      ignore_out = 1'b1;
      beat(1, 1, 2'b00, 1'b0);
      beat(2, 2, 2'b00, 1'b1);
      chk("t6_err_clear", 32'(err), 32'h0);
      beat(3, 3, 2'b10, 1'b0);
      chk("t6_err_lane_mis", 32'(err), 32'h1);
      beat(4, 4, 2'b01, 1'b1);
      for (int k = 0; k < 4; k++) beat(k, k, (k == 3) ? 2'b11 : 2'b00, 1'b0);
      idle();
      repeat (5) @(negedge clk);
      chk("t6_err_sticky", 32'(err), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      gap(1);
      chk("t6_err_rst", 32'(err), 32'h0);
      for (int k = 0; k < 4; k++) beat(k, k, (k == 3) ? 2'b11 : 2'b00, 1'b0);
      beat(1, 1, 2'b00, 1'b0);
      beat(2, 2, 2'b00, 1'b0);
      chk("t6_err_len_before", 32'(err), 32'h0);
      beat(3, 3, 2'b11, 1'b0);
      chk("t6_err_len", 32'(err), 32'h1);
      idle();
      gap(3);

      chk("sb_empty", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
